// File: rtl/num_rom_arbiter_if.sv
// num_rom_arbiter_if
// Request/response bus between the glyph-drawing clients and the shared
// font-ROM arbiter.
//   req_valid  [NREQ]     per-client request
//   req_addr   [NREQ*AW]  per-client ROM address, client i at [i*AW +: AW]
//   req_last   [NREQ]     final beat of the client's glyph burst
//   req_ready  [NREQ]     one-hot accept from the arbiter
//   rsp_valid             ROM line valid this cycle
//   rsp_id     [IDW]      client index owning the response
//   rsp_data   [DW]       ROM line
// modport slave is the arbiter side, modport master the client side.
interface num_rom_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 13,
    parameter int DW   = 20,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_addr, req_last,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_last,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/num_rom_arbiter.sv
// num_rom_arbiter
// Shares one synchronous-read font ROM between NREQ drawing clients.
// Round-robin grant, with a burst lock so that a client fetches all lines of
// a glyph back-to-back. Every ROM line comes back two cycles after its beat
// was accepted, tagged with the index of the requesting client.
//   clk       system clock
//   rst_n     asynchronous reset, active low
//   bus       request/response bus (slave side)
//   rom_addr  registered ROM address
//   rom_data  ROM read data (one-cycle synchronous read)
//   busy      lock held or a beat still in the read pipeline
module num_rom_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 13,
    parameter int DW   = 20,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    num_rom_arbiter_if.slave    bus,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    output logic                busy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state_reg;
    logic [IDW-1:0] owner_reg;
    logic [IDW-1:0] rr_ptr_reg;
    logic [AW-1:0]  rom_addr_reg;
    logic           s1_valid_reg;
    logic [IDW-1:0] s1_id_reg;
    logic           s2_valid_reg;
    logic [IDW-1:0] s2_id_reg;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [NREQ-1:0] ready_vec;
    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic            accept;
    logic [AW-1:0]   acc_addr;
    logic            acc_last;
    logic [IDW-1:0]  ptr_next;

    // Round-robin search: first pass looks at indices at or above the
    // pointer, second pass wraps around to the low indices.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j] && (IDW'(j) >= rr_ptr_reg)) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
    end

    // While locked the owner keeps ready even through bubbles.
    assign grant_id  = (state_reg == LOCK) ? owner_reg : win;
    assign grant_any = (state_reg == LOCK) | found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
            // Gated by rst_n so nothing is offered while reset is asserted.
            assign ready_vec[gi] = rst_n & grant_any & (grant_id == IDW'(gi));
        end
    endgenerate

    always_comb begin
        acc_addr = '0;
        acc_last = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_id == IDW'(j)) begin
                acc_addr = addr_arr[j];
                acc_last = bus.req_last[j];
            end
        end
    end

    assign accept   = |(bus.req_valid & ready_vec);
    assign ptr_next = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            rom_addr_reg <= '0;
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= '0;
            s2_valid_reg <= 1'b0;
            s2_id_reg    <= '0;
        end else begin
            // Two tag stages mirror the address register plus the ROM's
            // own output register.
            s1_valid_reg <= accept;
            s1_id_reg    <= grant_id;
            s2_valid_reg <= s1_valid_reg;
            s2_id_reg    <= s1_id_reg;
            if (accept) begin
                rom_addr_reg <= acc_addr;
                if (acc_last) begin
                    state_reg  <= IDLE;
                    rr_ptr_reg <= ptr_next;
                end else begin
                    state_reg <= LOCK;
                    owner_reg <= grant_id;
                end
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = s2_valid_reg;
    assign bus.rsp_id    = s2_id_reg;
    assign bus.rsp_data  = rom_data;
    assign rom_addr      = rom_addr_reg;
    assign busy          = (state_reg == LOCK) | s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_num_rom_arbiter.sv
module tb_num_rom_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 13;
    localparam int DW   = 20;
    localparam int IDW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;

    num_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) bus ();

    num_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Font ROM stand-in: one known glyph line, a hash everywhere else.
    function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
        if (a == 13'h312) return 20'h00018;
        return {a[6:0], a} ^ 20'h5A5A5;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    // Reference model state
    int            m_owner = -1;   // -1: no lock
    int            m_ptr = 0;
    logic          h1 = 1'b0, h2 = 1'b0;
    logic [AW-1:0] m_rom_addr = '0;
    int            grants[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(int i, logic v, logic [AW-1:0] a, logic l);
        bus.req_valid[i]         = v;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_last[i]          = l;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, 1'b0);
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_ptr      = 0;
        h1         = 1'b0;
        h2         = 1'b0;
        m_rom_addr = '0;
        q.delete();
    endtask

    // One clock cycle: compare against the model at the negedge, record the
    // expected response for any accepted beat, return after the next posedge.
    task automatic step(output logic [NREQ-1:0] acc);
        logic [NREQ-1:0] er;
        logic            got;
        int              g;
        exp_t            e;
        @(negedge clk);
        er  = '0;
        got = 1'b0;
        if (m_owner >= 0) begin
            er[m_owner] = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (!got && bus.req_valid[idx]) begin
                    er[idx] = 1'b1;
                    got     = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || h1 || h2));
        chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
        acc = bus.req_valid & er;
        h2  = h1;
        h1  = (acc != 0);
        if (acc != 0) begin
            g = 0;
            for (int i = 0; i < NREQ; i++) if (acc[i]) g = i;
            e.id   = g;
            e.data = rom_fn(bus.req_addr[g*AW +: AW]);
            e.due  = cyc + 2;
            q.push_back(e);
            m_rom_addr = bus.req_addr[g*AW +: AW];
            grants.push_back(g);
            if (bus.req_last[g]) begin
                m_owner = -1;
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_owner = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        logic [NREQ-1:0] a;
        clear_all();
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic chk_grants(string name, int exp[$]);
        chk({name, "_len"}, 32'(grants.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < grants.size(); i++)
            chk(name, 32'(grants[i]), 32'(exp[i]));
        grants.delete();
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents a line.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid) begin
                tests++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response (cycle %0d)",
                             bus.rsp_id, bus.rsp_data, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.rsp_id !== IDW'(e.id) || bus.rsp_data !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL rsp: got id %0d data %0h cycle %0d, expected id %0d data %0h cycle %0d",
                                 bus.rsp_id, bus.rsp_data, cyc, e.id, e.data, e.due);
                    end else begin
                        $display("[TB] rsp id %0d data %05h cycle %0d", bus.rsp_id, bus.rsp_data, cyc);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                tests++;
                errors++;
                $display("FAIL rsp_missing: got none, expected id %0d data %0h at cycle %0d",
                         q[0].id, q[0].data, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] acc;
        int beats;
        int bl[NREQ];
        logic [6:0] ch[NREQ];
        int ln[NREQ];

        clear_all();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        idle(2);
        grants.delete();

        // Round robin, single-beat requests from everyone
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(13'h040 + i), 1'b1);
        for (int k = 0; k < 6; k++) step(acc);
        chk_grants("rr_order", '{0, 1, 2, 0, 1, 2});
        idle(4);

        // Single beat with a known ROM line
        set_req(0, 1'b1, 13'h312, 1'b1);
        step(acc);
        chk("single_acc", 32'(acc), 32'b001);
        idle(4);
        grants.delete();

        // Burst lock: client 1 fetches 16 lines while 0 and 2 wait
        set_req(0, 1'b1, 13'h011, 1'b1);
        set_req(2, 1'b1, 13'h022, 1'b1);
        beats = 0;
        for (int g = 0; g < 40 && beats < 16; g++) begin
            set_req(1, 1'b1, AW'(13'h320 + beats), beats == 15);
            step(acc);
            if (acc[1]) beats++;
        end
        set_req(1, 1'b0, '0, 1'b0);
        step(acc);
        step(acc);
        chk_grants("burst_order", '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0});
        idle(4);

        // Bubble inside a lock: owner drops valid for 3 cycles
        set_req(0, 1'b1, 13'h015, 1'b1);
        set_req(2, 1'b1, 13'h025, 1'b1);
        set_req(1, 1'b1, 13'h100, 1'b0);
        step(acc);
        set_req(1, 1'b0, 13'h101, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(acc);
            chk("bubble_busy", 32'(busy), 32'd1);
        end
        set_req(1, 1'b1, 13'h101, 1'b1);
        step(acc);
        set_req(1, 1'b0, '0, 1'b0);
        step(acc);
        step(acc);
        chk_grants("bubble_order", '{1, 1, 2, 0});
        idle(4);

        // Reset with two beats in flight
        set_req(1, 1'b1, 13'h200, 1'b0);
        step(acc);
        set_req(1, 1'b1, 13'h201, 1'b0);
        step(acc);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
        model_reset();
        grants.delete();
        clear_all();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(2, 1'b1, 13'h0AA, 1'b1);
        step(acc);
        chk("rst_after_acc", 32'(acc), 32'b100);
        idle(4);
        grants.delete();

        // Pointer wrap: after client 1 finishes, only 0 and 1 request
        set_req(1, 1'b1, 13'h031, 1'b1);
        step(acc);
        set_req(0, 1'b1, 13'h030, 1'b1);
        for (int k = 0; k < 2; k++) step(acc);
        chk_grants("wrap_order", '{1, 0, 1});
        idle(4);
        grants.delete();

        // Randomised traffic with bursts, bubbles and competing clients
        for (int i = 0; i < NREQ; i++) begin
            bl[i] = 0;
            ch[i] = '0;
            ln[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bl[i] == 0 && $urandom_range(2) == 0) begin
                    bl[i] = ($urandom_range(7) == 0) ? 16 : int'($urandom_range(4, 1));
                    ch[i] = 7'($urandom);
                    ln[i] = 0;
                end
                set_req(i, (bl[i] > 0) && ($urandom_range(4) != 0),
                        {ch[i], 6'(ln[i])}, bl[i] == 1);
            end
            step(acc);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    bl[i]--;
                    ln[i]++;
                end
            end
        end
        grants.delete();
        idle(6);
        chk("drain_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
